uart_bus_bridge: RTL and testbench

- UART-driven bus initiator: decodes a byte command stream from the UART receiver and issues word reads/writes on the CPU-side memory bus (vaddr/data/byteena/memWE/memWait/q). Sends responses through the UART transmitter.
- This is the initiator end of the bus that the memory/UART responder serves. Used for program loading and debug.
- Top level muxes its bus outputs against the CPU whenever `active` is high.

---
 rtl/bridge_pkg.sv | 31 +++
 rtl/bridge_tx_seq.sv | 75 +++++++
 rtl/uart_bus_bridge.sv | 178 +++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and byte constants for the UART-to-bus bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WDATA   = 3'd2,
    ST_BUS_WR  = 3'd3,
    ST_BUS_RD  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_TX      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_LOAD   = 2'd1,
    TS_STROBE = 2'd2,
    TS_WAIT   = 2'd3
  } tx_state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  // True for the two opcodes that start an addressed command.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/bridge_tx_seq.sv
// Response byte sequencer: sends 1 or 4 bytes of a word, LSB first,
// handshaking with the UART transmitter, then pulses o_done.
module bridge_tx_seq
  import bridge_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_word,
  input  logic        i_four,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_we,
  output logic        o_done
);

  tx_state_t   r_state;
  logic [31:0] r_shift;
  logic [1:0]  r_left;
  logic [7:0]  r_tx_data;
  logic        r_tx_we;
  logic        r_done;

  assign o_tx_data = r_tx_data;
  assign o_tx_we   = r_tx_we;
  assign o_done    = r_done;

  // Byte sequencing; busy is ignored in the strobe cycle since the transmitter reacts one cycle late.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= TS_IDLE;
      r_shift   <= 32'h0000_0000;
      r_left    <= 2'd0;
      r_tx_data <= 8'h00;
      r_tx_we   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tx_we <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        TS_IDLE: begin
          if (i_start) begin
            r_shift <= i_word;
            r_left  <= i_four ? 2'd3 : 2'd0;
            r_state <= TS_LOAD;
          end
        end
        TS_LOAD: begin
          if (!i_tx_busy) begin
            r_tx_data <= r_shift[7:0];
            r_tx_we   <= 1'b1;
            r_state   <= TS_STROBE;
          end
        end
        TS_STROBE: begin
          r_state <= TS_WAIT;
        end
        TS_WAIT: begin
          if (!i_tx_busy) begin
            if (r_left != 2'd0) begin
              r_shift <= {8'h00, r_shift[31:8]};
              r_left  <= r_left - 2'd1;
              r_state <= TS_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= TS_IDLE;
            end
          end
        end
        default: r_state <= TS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command decoder acting as a bus initiator: little-endian word
// writes (0x57) and reads (0x52), ACK/NAK or read data sent back.
module uart_bus_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_fin,
  output logic [7:0]  tx_data,
  output logic        tx_we,
  input  logic        tx_busy,
  output logic [31:0] vaddr,
  output logic [31:0] data,
  output logic [3:0]  byteena,
  output logic        memWE,
  input  logic        memWait,
  input  logic [31:0] q,
  output logic        active,
  output logic        overrun
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);

  state_t      r_state;
  logic        r_is_write;
  logic [1:0]  r_idx;
  logic [TW-1:0] r_tcnt;
  logic [LW-1:0] r_lat;
  logic [31:0] r_vaddr;
  logic [31:0] r_data;
  logic [3:0]  r_byteena;
  logic        r_memwe;
  logic        r_active;
  logic        r_overrun;
  logic [31:0] r_tx_word;
  logic        r_tx_four;
  logic        r_tx_start;
  logic        w_tx_done;
  logic        w_accepting;

  assign vaddr   = r_vaddr;
  assign data    = r_data;
  assign byteena = r_byteena;
  assign memWE   = r_memwe;
  assign active  = r_active;
  assign overrun = r_overrun;

  assign w_accepting = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_WDATA);

  bridge_tx_seq u_tx_seq (
    .clock     (clock),
    .reset     (reset),
    .i_start   (r_tx_start),
    .i_word    (r_tx_word),
    .i_four    (r_tx_four),
    .i_tx_busy (tx_busy),
    .o_tx_data (tx_data),
    .o_tx_we   (tx_we),
    .o_done    (w_tx_done)
  );

  // Command FSM: collect bytes, run one bus access, hand the response to the sequencer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_is_write <= 1'b0;
      r_idx      <= 2'd0;
      r_tcnt     <= '0;
      r_lat      <= '0;
      r_vaddr    <= 32'h0000_0000;
      r_data     <= 32'h0000_0000;
      r_byteena  <= 4'h0;
      r_memwe    <= 1'b0;
      r_active   <= 1'b0;
      r_overrun  <= 1'b0;
      r_tx_word  <= 32'h0000_0000;
      r_tx_four  <= 1'b0;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_memwe    <= 1'b0;
      r_byteena  <= 4'h0;
      if (rx_fin && !w_accepting) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (rx_fin) begin
            r_active <= 1'b1;
            if (is_opcode(rx_data)) begin
              r_is_write <= (rx_data == OP_WRITE);
              r_overrun  <= 1'b0;
              r_idx      <= 2'd0;
              r_tcnt     <= '0;
              r_state    <= ST_ADDR;
            end else begin
              r_tx_word  <= {24'h000000, RSP_NAK};
              r_tx_four  <= 1'b0;
              r_tx_start <= 1'b1;
              r_state    <= ST_TX;
            end
          end
        end
        ST_ADDR: begin
          if (rx_fin) begin
            r_vaddr[{r_idx, 3'b000} +: 8] <= rx_data;
            r_idx  <= r_idx + 2'd1;
            r_tcnt <= '0;
            if (r_idx == 2'd3) begin
              r_state <= r_is_write ? ST_WDATA : ST_BUS_RD;
            end
          end else if (r_tcnt == TO_LAST) begin
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        ST_WDATA: begin
          if (rx_fin) begin
            r_data[{r_idx, 3'b000} +: 8] <= rx_data;
            r_idx  <= r_idx + 2'd1;
            r_tcnt <= '0;
            if (r_idx == 2'd3) begin
              r_state <= ST_BUS_WR;
            end
          end else if (r_tcnt == TO_LAST) begin
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        ST_BUS_WR: begin
          if (!memWait) begin
            r_memwe    <= 1'b1;
            r_byteena  <= 4'hF;
            r_tx_word  <= {24'h000000, RSP_ACK};
            r_tx_four  <= 1'b0;
            r_tx_start <= 1'b1;
            r_state    <= ST_TX;
          end
        end
        ST_BUS_RD: begin
          if (!memWait) begin
            r_lat   <= '0;
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (r_lat == LAT_LAST) begin
            r_tx_word  <= q;
            r_tx_four  <= 1'b1;
            r_tx_start <= 1'b1;
            r_state    <= ST_TX;
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        ST_TX: begin
          if (w_tx_done) begin
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge with a transmitter/bus monitor
// and per-feature test tasks driven by $urandom stimulus.
module tb_uart_bus_bridge;

  localparam int RL = 2;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_fin = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy = 1'b0;
  logic [31:0] vaddr;
  logic [31:0] data;
  logic [3:0]  byteena;
  logic        memWE;
  logic        memWait = 1'b0;
  logic [31:0] q = 32'hA5A5_A5A5;
  logic        active;
  logic        overrun;

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int be_glitch = 0;
  int busy_min = 1;
  int busy_max = 0;
  int busy_left = 0;
  logic [7:0]  tx_q[$];
  logic [67:0] wr_q[$];
  int          wr_cyc_q[$];

  uart_bus_bridge #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_fin(rx_fin),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .vaddr(vaddr), .data(data), .byteena(byteena), .memWE(memWE),
    .memWait(memWait), .q(q), .active(active), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Transmitter and bus observer: records strobes, models a busy transmitter.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (tx_we === 1'b1) begin
        tx_q.push_back(tx_data);
        busy_left = (busy_max > 0) ? $urandom_range(busy_max, busy_min) : 0;
      end
      if (memWE === 1'b1) begin
        wr_q.push_back({vaddr, data, byteena});
        wr_cyc_q.push_back(cyc);
      end else if (byteena !== 4'h0) begin
        be_glitch++;
      end
      if (busy_left > 0) begin
        tx_busy = 1'b1;
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data = b;
    rx_fin  = 1'b1;
    @(negedge clock);
    rx_fin  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_obs();
    tx_q.delete();
    wr_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d, input int gap);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) begin
      idle_cycles($urandom_range(gap, 0));
      send_byte(a[8*i +: 8]);
    end
    for (int i = 0; i < 4; i++) begin
      idle_cycles($urandom_range(gap, 0));
      send_byte(d[8*i +: 8]);
    end
  endtask

  // The responder presents q only in the cycle READ_LATENCY after the address cycle.
  task automatic send_read(input logic [31:0] a, input logic [31:0] rd, input int gap);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) begin
      idle_cycles($urandom_range(gap, 0));
      send_byte(a[8*i +: 8]);
    end
    repeat (RL) @(posedge clock);
    #1 q = rd;
    @(posedge clock);
    #1 q = ~rd;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (active === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_reset();
    logic [79:0] obs;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 obs = {vaddr, data, byteena, memWE, tx_data, tx_we, active, overrun};
    n_checks++;
    if (obs !== 80'h0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_write();
    logic [31:0] a, d;
    logic [67:0] got;
    bit ok;
    for (int k = 0; k < 5; k++) begin
      a = (k == 0) ? 32'h0000_0010 : $urandom;
      d = (k == 0) ? 32'hDEAD_BEEF : $urandom;
      busy_max = k;
      clear_obs();
      send_write(a, d, (k == 0) ? 0 : 3);
      wait_idle(ok);
      n_checks++;
      if (!ok) $display("FAIL write_done: active stuck at %b, expected 0", active);
      else n_pass++;
      got = (wr_q.size() > 0) ? wr_q[0] : 68'h0;
      n_checks++;
      if (wr_q.size() != 1 || got !== {a, d, 4'hF})
        $display("FAIL write_bus: %0d writes, first %h expected one of %h", wr_q.size(), got, {a, d, 4'hF});
      else n_pass++;
      n_checks++;
      if (tx_q.size() != 1 || tx_q[0] !== 8'h06)
        $display("FAIL write_ack: %0d tx bytes, expected single 06", tx_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_read();
    logic [31:0] a, rd;
    logic [7:0]  exp_tx[$];
    bit ok, bad;
    for (int k = 0; k < 5; k++) begin
      a  = (k == 0) ? 32'h0000_0010 : $urandom;
      rd = (k == 0) ? 32'h1234_5678 : $urandom;
      busy_max = 2 * k;
      clear_obs();
      exp_tx.delete();
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'((rd >> (8 * i)) & 32'hFF));
      send_read(a, rd, (k == 0) ? 0 : 3);
      wait_idle(ok);
      bad = !ok || (tx_q.size() != 4);
      for (int i = 0; i < 4 && !bad; i++) if (tx_q[i] !== exp_tx[i]) bad = 1'b1;
      n_checks++;
      if (bad) $display("FAIL read_resp: %0d bytes, first %h, expected 4 bytes of %h LSB first",
                        tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'h00, rd);
      else n_pass++;
      n_checks++;
      if (wr_q.size() != 0 || vaddr !== a) $display("FAIL read_bus: writes=%0d vaddr=%h expected 0 writes vaddr=%h", wr_q.size(), vaddr, a);
      else n_pass++;
    end
  endtask

  task automatic test_memwait();
    logic [31:0] a, d;
    int drop_cyc;
    bit ok;
    a = $urandom;
    d = $urandom;
    busy_max = 0;
    clear_obs();
    memWait = 1'b1;
    send_write(a, d, 1);
    idle_cycles(5);
    n_checks++;
    if (wr_q.size() != 0) $display("FAIL memwait_hold: %0d writes while stalled, expected 0", wr_q.size());
    else n_pass++;
    drop_cyc = cyc;
    memWait = 1'b0;
    wait_idle(ok);
    n_checks++;
    if (!ok || wr_q.size() != 1 || wr_cyc_q[0] != drop_cyc + 1)
      $display("FAIL memwait_strobe: %0d writes at cyc %0d, expected 1 at cyc %0d",
               wr_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, drop_cyc + 1);
    else n_pass++;
  endtask

  task automatic test_bad_opcode();
    logic [7:0] op;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      op = (k == 0) ? 8'hAA : 8'($urandom);
      if (op == 8'h57 || op == 8'h52) op = 8'h00;
      busy_max = k;
      clear_obs();
      send_byte(op);
      wait_idle(ok);
      n_checks++;
      if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h15 || wr_q.size() != 0)
        $display("FAIL bad_opcode: op %h gave %0d tx bytes, %0d writes; expected one 15, no writes",
                 op, tx_q.size(), wr_q.size());
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (TO - 1) @(posedge clock);
    #1;
    n_checks++;
    if (active !== 1'b1) $display("FAIL timeout_early: active=%b after %0d idle cycles, expected 1", active, TO - 1);
    else n_pass++;
    @(posedge clock);
    #1;
    n_checks++;
    if (active !== 1'b0) $display("FAIL timeout_abort: active=%b after %0d idle cycles, expected 0", active, TO);
    else n_pass++;
    idle_cycles(10);
    n_checks++;
    if (tx_q.size() != 0 || wr_q.size() != 0)
      $display("FAIL timeout_quiet: tx=%0d writes=%0d, expected 0/0", tx_q.size(), wr_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [79:0] obs;
    logic [31:0] rd;
    bit ok, bad;
    clear_obs();
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clock);
    reset = 1'b0;
    #1 obs = {vaddr, data, byteena, memWE, tx_data, tx_we, active, overrun};
    n_checks++;
    if (obs !== 80'h0) $display("FAIL reset_mid_outputs: got %h expected 0", obs);
    else n_pass++;
    idle_cycles(2);
    reset = 1'b1;
    rd = $urandom;
    send_read(32'h0000_0100, rd, 2);
    wait_idle(ok);
    bad = !ok || (tx_q.size() != 4) || (wr_q.size() != 0);
    for (int i = 0; i < 4 && !bad; i++) if (tx_q[i] !== 8'((rd >> (8 * i)) & 32'hFF)) bad = 1'b1;
    n_checks++;
    if (bad) $display("FAIL reset_mid_read: tx=%0d writes=%0d, expected 4 bytes of %h and 0 writes",
                      tx_q.size(), wr_q.size(), rd);
    else n_pass++;
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    bit ok, seen;
    rd = $urandom;
    busy_min = 8;
    busy_max = 8;
    clear_obs();
    send_read($urandom, rd, 0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (tx_q.size() > 0) seen = 1'b1;
    end
    send_byte(8'h57);
    n_checks++;
    if (!seen || overrun !== 1'b1) $display("FAIL overrun_set: overrun=%b (tx seen %b), expected 1", overrun, seen);
    else n_pass++;
    wait_idle(ok);
    n_checks++;
    if (!ok || tx_q.size() != 4 || tx_q[3] !== rd[31:24] || overrun !== 1'b1)
      $display("FAIL overrun_drop: tx=%0d overrun=%b, expected 4 bytes and sticky 1", tx_q.size(), overrun);
    else n_pass++;
    busy_min = 1;
    busy_max = 0;
    clear_obs();
    send_read($urandom, rd, 0);
    wait_idle(ok);
    n_checks++;
    if (!ok || overrun !== 1'b0) $display("FAIL overrun_clear: overrun=%b after new command, expected 0", overrun);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    logic [7:0]  exp_tx[$];
    logic [67:0] exp_wr[$];
    int kind;
    bit ok, bad;
    clear_obs();
    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(2, 0);
      a = $urandom;
      d = $urandom;
      busy_max = $urandom_range(3, 0);
      if (kind == 0) begin
        send_write(a, d, 2);
        exp_wr.push_back({a, d, 4'hF});
        exp_tx.push_back(8'h06);
      end else if (kind == 1) begin
        send_read(a, d, 2);
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'((d >> (8 * i)) & 32'hFF));
      end else begin
        send_byte(8'hC3);
        exp_tx.push_back(8'h15);
      end
      for (int i = 0; i < 400 && active === 1'b1; i++) @(negedge clock);
    end
    wait_idle(ok);
    bad = !ok || (tx_q.size() != exp_tx.size()) || (wr_q.size() != exp_wr.size());
    for (int i = 0; i < exp_tx.size() && !bad; i++) if (tx_q[i] !== exp_tx[i]) bad = 1'b1;
    for (int i = 0; i < exp_wr.size() && !bad; i++) if (wr_q[i] !== exp_wr[i]) bad = 1'b1;
    n_checks++;
    if (bad) $display("FAIL back_to_back: tx=%0d/%0d writes=%0d/%0d (got/expected)",
                      tx_q.size(), exp_tx.size(), wr_q.size(), exp_wr.size());
    else n_pass++;
    n_checks++;
    if (be_glitch != 0) $display("FAIL byteena_idle: %0d cycles with byteena set and memWE low, expected 0", be_glitch);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_memwait();
    test_bad_opcode();
    test_timeout();
    test_reset_mid();
    test_overrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
